wb_regfile: RTL and testbench

//   Write-back stage and architectural register file of the MIPS pipeline; consumes the
//   MEM/WB pipeline register outputs. Selects write-back data (memory vs ALU), commits it
//   to a 32x32 register file, and serves two ID-stage read ports with same-cycle
//   WB->ID bypass. Also counts committed writes for debug/perf.

---
 rtl/wb_regfile.sv | 61 ++++++
 tb/tb_wb_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects memory/ALU result, commits it to a 32x32 register file,
// and serves two ID read ports with same-cycle WB->ID bypass plus a registered debug port.
module wb_regfile #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  SP_INIT = 32'h0000_03FC,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [4:0]        WriteRegister,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WBData,
    output logic              WBValid,
    input  logic [4:0]        DbgAddr,
    output logic [DATA_W-1:0] DbgData,
    output logic [CNT_W-1:0]  WriteCount
);

    logic [31:0][DATA_W-1:0] regs;

    assign WBData  = MemtoReg ? ReadData : ALUResult;
    assign WBValid = RegWrite & enable & (WriteRegister != 5'd0);

    // Bypass covers the missing write-before-read half cycle: an in-flight commit wins.
    function automatic logic [DATA_W-1:0] rd_port(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        else if (WBValid && (WriteRegister == idx))
            return WBData;
        else
            return regs[idx];
    endfunction

    assign ReadData1 = rd_port(ReadReg1);
    assign ReadData2 = rd_port(ReadReg2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 29) ? SP_INIT : '0;
            DbgData    <= '0;
            WriteCount <= '0;
        end else begin
            if (WBValid) begin
                regs[WriteRegister] <= WBData;
                WriteCount          <= WriteCount + CNT_W'(1);
            end
            // Debug view is the pre-write contents; it keeps sampling during stalls.
            DbgData <= (DbgAddr == 5'd0) ? '0 : regs[DbgAddr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations are queued when stimulus is driven and
// popped in order when the corresponding DUT output is sampled.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              MemtoReg;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] ALUResult;
    logic [4:0]        WriteRegister;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WBData;
    logic              WBValid;
    logic [4:0]        DbgAddr;
    logic [DATA_W-1:0] DbgData;
    logic [CNT_W-1:0]  WriteCount;

    wb_regfile #(.DATA_W(DATA_W), .SP_INIT(32'h0000_03FC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ReadData(ReadData), .ALUResult(ALUResult),
        .WriteRegister(WriteRegister), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WBData(WBData),
        .WBValid(WBValid), .DbgAddr(DbgAddr), .DbgData(DbgData),
        .WriteCount(WriteCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; MemtoReg = 1'b0; RegWrite = 1'b0;
        ReadData = '0; ALUResult = '0; WriteRegister = '0;
        ReadReg1 = 5'd29; ReadReg2 = 5'd5; DbgAddr = 5'd0;

        // Reset pulsed mid-cycle: contents visible asynchronously
        #7 reset = 1'b0;
        sb_push("rst_sp", 32'h3FC); sb_push("rst_r5", 32'h0);
        sb_push("rst_cnt", 32'h0);  sb_push("rst_dbg", 32'h0);
        #1;
        sb_check(ReadData1); sb_check(ReadData2);
        sb_check(32'(WriteCount)); sb_check(DbgData);
        @(negedge clk) reset = 1'b1;

        // ALU write-back to $8, bypass visible before the edge
        RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'hDEAD_BEEF;
        WriteRegister = 5'd8; ReadReg1 = 5'd8; ReadReg2 = 5'd29;
        sb_push("alu_wbdata", 32'hDEAD_BEEF); sb_push("alu_wbvalid", 32'h1);
        sb_push("alu_bypass", 32'hDEAD_BEEF); sb_push("alu_sp", 32'h3FC);
        #1;
        sb_check(WBData); sb_check(32'(WBValid)); sb_check(ReadData1); sb_check(ReadData2);
        @(negedge clk) RegWrite = 1'b0;
        sb_push("alu_rd8", 32'hDEAD_BEEF); sb_push("alu_cnt", 32'h1);
        #1;
        sb_check(ReadData1); sb_check(32'(WriteCount));

        // Load write-back to $9, both ports bypass
        @(negedge clk);
        RegWrite = 1'b1; MemtoReg = 1'b1; ReadData = 32'h1234; ALUResult = 32'h5555;
        WriteRegister = 5'd9; ReadReg1 = 5'd9; ReadReg2 = 5'd9;
        sb_push("ld_wbdata", 32'h1234); sb_push("ld_byp1", 32'h1234); sb_push("ld_byp2", 32'h1234);
        #1;
        sb_check(WBData); sb_check(ReadData1); sb_check(ReadData2);
        @(negedge clk) RegWrite = 1'b0;
        sb_push("ld_rd1", 32'h1234); sb_push("ld_rd2", 32'h1234); sb_push("ld_cnt", 32'h2);
        #1;
        sb_check(ReadData1); sb_check(ReadData2); sb_check(32'(WriteCount));

        // $0 guard
        @(negedge clk);
        RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'h5;
        WriteRegister = 5'd0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        sb_push("z_wbvalid", 32'h0); sb_push("z_rd1", 32'h0);
        #1;
        sb_check(32'(WBValid)); sb_check(ReadData1);
        @(negedge clk) RegWrite = 1'b0;
        sb_push("z_rd2", 32'h0); sb_push("z_cnt", 32'h2);
        #1;
        sb_check(ReadData2); sb_check(32'(WriteCount));

        // Stall: no commit, no bypass, debug port still samples
        @(negedge clk);
        enable = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'h7;
        WriteRegister = 5'd10; ReadReg1 = 5'd10; DbgAddr = 5'd8;
        sb_push("st_wbvalid", 32'h0); sb_push("st_nobyp", 32'h0);
        #1;
        sb_check(32'(WBValid)); sb_check(ReadData1);
        @(negedge clk);
        sb_push("st_rd10", 32'h0); sb_push("st_cnt", 32'h2); sb_push("st_dbg", 32'hDEAD_BEEF);
        #1;
        sb_check(ReadData1); sb_check(32'(WriteCount)); sb_check(DbgData);
        @(negedge clk) enable = 1'b1;
        sb_push("st_resume_byp", 32'h7);
        #1;
        sb_check(ReadData1);
        @(negedge clk) RegWrite = 1'b0;
        sb_push("st_resume_rd", 32'h7); sb_push("st_resume_cnt", 32'h3);
        #1;
        sb_check(ReadData1); sb_check(32'(WriteCount));

        // Counter wrap: 13 more commits take the 4-bit count from 3 through 15 to 0
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            RegWrite = 1'b1; WriteRegister = 5'd10; ALUResult = 32'h100 + 32'(i);
            sb_push("wrap_cnt", 32'((4 + i) % 16));
            @(negedge clk) RegWrite = 1'b0;
            #1 sb_check(32'(WriteCount));
        end

        // Debug port: one cycle latency, no bypass
        @(negedge clk) DbgAddr = 5'd10;
        sb_push("dbg_latency", 32'hDEAD_BEEF);
        #1 sb_check(DbgData);
        @(negedge clk);
        sb_push("dbg_rd10", 32'h10C);
        #1 sb_check(DbgData);

        // Reset held across an edge with a commit pending: the write is lost
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd11; ALUResult = 32'hABC; reset = 1'b0;
        @(negedge clk);
        RegWrite = 1'b0; reset = 1'b1; ReadReg1 = 5'd11; ReadReg2 = 5'd8;
        sb_push("rst2_rd11", 32'h0); sb_push("rst2_rd8", 32'h0); sb_push("rst2_cnt", 32'h0);
        #1;
        sb_check(ReadData1); sb_check(ReadData2); sb_check(32'(WriteCount));
        ReadReg1 = 5'd29;
        sb_push("rst2_sp", 32'h3FC);
        #1 sb_check(ReadData1);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
